// File: rtl/rob_multi.sv
// rob_multi: N-wide dispatch, M-wide in-order commit reorder buffer with mispredict flush
module rob_multi #(
  parameter int ROB_DEPTH = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int CDB_SIZE = 3,
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DISPATCH_WIDTH-1:0]             i_dispatch_valid,
  input  logic [DISPATCH_WIDTH-1:0][4:0]        i_dispatch_rd_s,
  input  logic [DISPATCH_WIDTH-1:0]             i_dispatch_regf_we,
  input  logic [DISPATCH_WIDTH-1:0][31:0]       i_dispatch_pc,
  input  logic [DISPATCH_WIDTH-1:0][31:0]       i_dispatch_pc_next,
  output logic                                  o_dispatch_ready,
  output logic [DISPATCH_WIDTH-1:0][TW-1:0]     o_dispatch_tag,
  input  logic [CDB_SIZE-1:0]                   i_cdb_valid,
  input  logic [CDB_SIZE-1:0][TW-1:0]           i_cdb_tag,
  input  logic [CDB_SIZE-1:0][31:0]             i_cdb_data,
  input  logic                                  i_br_valid,
  input  logic [TW-1:0]                         i_br_tag,
  input  logic [31:0]                           i_br_target,
  input  logic                                  i_br_taken,
  input  logic [31:0]                           i_br_rd_v,
  output logic [COMMIT_WIDTH-1:0]               o_commit_valid,
  output logic [COMMIT_WIDTH-1:0][TW-1:0]       o_commit_tag,
  output logic [COMMIT_WIDTH-1:0]               o_commit_regf_we,
  output logic [COMMIT_WIDTH-1:0][4:0]          o_commit_rd_s,
  output logic [COMMIT_WIDTH-1:0][31:0]         o_commit_rd_v,
  output logic [COMMIT_WIDTH-1:0][31:0]         o_commit_pc,
  output logic [COMMIT_WIDTH-1:0]               o_commit_br_taken,
  output logic                                  o_flush,
  output logic [31:0]                           o_flush_pc,
  output logic [TW:0]                           o_rob_count,
  output logic                                  o_rob_empty
);
  logic [TW:0] r_head, r_tail, w_count, w_ndisp, w_ncommit;
  logic [ROB_DEPTH-1:0] r_valid, r_ready, r_mispred, r_taken, r_we;
  logic [4:0] r_rd_s [ROB_DEPTH];
  logic [31:0] r_rd_v [ROB_DEPTH];
  logic [31:0] r_pc [ROB_DEPTH];
  logic [31:0] r_pc_next [ROB_DEPTH];
  logic [DISPATCH_WIDTH-1:0] w_disp;
  logic [COMMIT_WIDTH:0] w_chain;
  logic [COMMIT_WIDTH-1:0] w_flush_lane;
  logic [COMMIT_WIDTH-1:0][TW-1:0] w_cidx;
  assign w_count = r_tail - r_head;
  assign o_rob_count = w_count;
  assign o_rob_empty = w_count == '0;
  assign o_dispatch_ready = w_count <= (TW+1)'(ROB_DEPTH - DISPATCH_WIDTH);
  assign w_disp = o_dispatch_ready ? i_dispatch_valid : '0;
  assign w_chain[0] = !rst;
  assign o_flush = |w_flush_lane;
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_dtag
    assign o_dispatch_tag[k] = r_tail[TW-1:0] + TW'(k);
  end
  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_commit
    assign w_cidx[k] = r_head[TW-1:0] + TW'(k);
    assign o_commit_valid[k] = w_chain[k] && r_valid[w_cidx[k]] && r_ready[w_cidx[k]];
    assign w_chain[k+1] = o_commit_valid[k] && !r_mispred[w_cidx[k]];
    assign w_flush_lane[k] = o_commit_valid[k] && r_mispred[w_cidx[k]];
    assign o_commit_tag[k] = w_cidx[k];
    assign o_commit_regf_we[k] = o_commit_valid[k] && r_we[w_cidx[k]];
    assign o_commit_rd_s[k] = r_rd_s[w_cidx[k]];
    assign o_commit_rd_v[k] = r_rd_v[w_cidx[k]];
    assign o_commit_pc[k] = r_pc[w_cidx[k]];
    assign o_commit_br_taken[k] = r_taken[w_cidx[k]];
  end
  always_comb begin
    w_ndisp = '0;
    w_ncommit = '0;
    o_flush_pc = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) w_ndisp = w_ndisp + (TW+1)'(w_disp[k]);
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_ncommit = w_ncommit + (TW+1)'(o_commit_valid[k]);
      o_flush_pc = o_flush_pc | (w_flush_lane[k] ? r_pc_next[w_cidx[k]] : 32'h0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || o_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_valid <= '0;
      r_ready <= '0;
      r_mispred <= '0;
    end else begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (w_disp[k]) begin
          r_valid[o_dispatch_tag[k]] <= 1'b1;
          r_ready[o_dispatch_tag[k]] <= 1'b0;
          r_mispred[o_dispatch_tag[k]] <= 1'b0;
          r_taken[o_dispatch_tag[k]] <= 1'b0;
          r_we[o_dispatch_tag[k]] <= i_dispatch_regf_we[k];
          r_rd_s[o_dispatch_tag[k]] <= i_dispatch_rd_s[k];
          r_pc[o_dispatch_tag[k]] <= i_dispatch_pc[k];
          r_pc_next[o_dispatch_tag[k]] <= i_dispatch_pc_next[k];
        end
      end
      for (int j = CDB_SIZE - 1; j >= 0; j--) begin
        if (i_cdb_valid[j] && r_valid[i_cdb_tag[j]] && !r_ready[i_cdb_tag[j]]) begin
          r_ready[i_cdb_tag[j]] <= 1'b1;
          r_rd_v[i_cdb_tag[j]] <= i_cdb_data[j];
        end
      end
      if (i_br_valid && r_valid[i_br_tag]) begin
        r_ready[i_br_tag] <= 1'b1;
        r_taken[i_br_tag] <= i_br_taken;
        r_rd_v[i_br_tag] <= i_br_rd_v;
        if (i_br_target != r_pc_next[i_br_tag]) begin
          r_mispred[i_br_tag] <= 1'b1;
          r_pc_next[i_br_tag] <= i_br_target;
        end
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (o_commit_valid[k]) begin
          r_valid[w_cidx[k]] <= 1'b0;
          r_ready[w_cidx[k]] <= 1'b0;
          r_mispred[w_cidx[k]] <= 1'b0;
        end
      end
      r_head <= r_head + w_ncommit;
      r_tail <= r_tail + w_ndisp;
    end
  end
endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed self-checking bench for rob_multi
module tb_rob_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dispatch_valid;
  logic [1:0][4:0] dispatch_rd_s;
  logic [1:0] dispatch_regf_we;
  logic [1:0][31:0] dispatch_pc;
  logic [1:0][31:0] dispatch_pc_next;
  logic dispatch_ready;
  logic [1:0][3:0] dispatch_tag;
  logic [2:0] cdb_valid;
  logic [2:0][3:0] cdb_tag;
  logic [2:0][31:0] cdb_data;
  logic br_valid;
  logic [3:0] br_tag;
  logic [31:0] br_target;
  logic br_taken;
  logic [31:0] br_rd_v;
  logic [1:0] commit_valid;
  logic [1:0][3:0] commit_tag;
  logic [1:0] commit_regf_we;
  logic [1:0][4:0] commit_rd_s;
  logic [1:0][31:0] commit_rd_v;
  logic [1:0][31:0] commit_pc;
  logic [1:0] commit_br_taken;
  logic flush;
  logic [31:0] flush_pc;
  logic [4:0] rob_count;
  logic rob_empty;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rob_multi dut (
    .clk(clk), .rst(rst),
    .i_dispatch_valid(dispatch_valid), .i_dispatch_rd_s(dispatch_rd_s),
    .i_dispatch_regf_we(dispatch_regf_we), .i_dispatch_pc(dispatch_pc),
    .i_dispatch_pc_next(dispatch_pc_next), .o_dispatch_ready(dispatch_ready),
    .o_dispatch_tag(dispatch_tag), .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag),
    .i_cdb_data(cdb_data), .i_br_valid(br_valid), .i_br_tag(br_tag),
    .i_br_target(br_target), .i_br_taken(br_taken), .i_br_rd_v(br_rd_v),
    .o_commit_valid(commit_valid), .o_commit_tag(commit_tag),
    .o_commit_regf_we(commit_regf_we), .o_commit_rd_s(commit_rd_s),
    .o_commit_rd_v(commit_rd_v), .o_commit_pc(commit_pc),
    .o_commit_br_taken(commit_br_taken), .o_flush(flush), .o_flush_pc(flush_pc),
    .o_rob_count(rob_count), .o_rob_empty(rob_empty)
  );
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(dispatch_valid[1] && !dispatch_valid[0])) else $error("non-contiguous dispatch_valid");
      for (int i = 0; i < 3; i++)
        for (int j = i + 1; j < 3; j++)
          assert (!(cdb_valid[i] && cdb_valid[j] && cdb_tag[i] == cdb_tag[j])) else $error("duplicate cdb tag");
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    dispatch_valid = '0; dispatch_rd_s = '0; dispatch_regf_we = '0;
    dispatch_pc = '0; dispatch_pc_next = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    br_valid = 1'b0; br_tag = '0; br_target = '0; br_taken = 1'b0; br_rd_v = '0;
  endtask
  task automatic disp(input int lane, input logic [4:0] rd, input logic we, input logic [31:0] pc, input logic [31:0] pcn);
    dispatch_valid[lane] = 1'b1;
    dispatch_rd_s[lane] = rd;
    dispatch_regf_we[lane] = we;
    dispatch_pc[lane] = pc;
    dispatch_pc_next[lane] = pcn;
  endtask
  task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch] = tag;
    cdb_data[ch] = data;
  endtask
  task automatic do_reset;
    idle;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    do_reset;
    checks++; if (rob_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", rob_count); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", rob_empty); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", dispatch_ready); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit got %b exp 00", commit_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
  endtask
  task automatic test_fill;
    do_reset;
    for (int c = 0; c < 8; c++) begin
      checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready c%0d got %b exp 1", c, dispatch_ready); end
      checks++; if (dispatch_tag[0] !== 4'(2 * c)) begin errors++; $display("FAIL fill_tag c%0d got %0d exp %0d", c, dispatch_tag[0], 2 * c); end
      disp(0, 5'd1, 1'b1, 32'h100 + 32'(8 * c), 32'h104 + 32'(8 * c));
      disp(1, 5'd2, 1'b1, 32'h104 + 32'(8 * c), 32'h108 + 32'(8 * c));
      tick;
      checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL fill_commit c%0d got %b exp 00", c, commit_valid); end
    end
    idle;
    checks++; if (rob_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", rob_count); end
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", dispatch_ready); end
    checks++; if (rob_empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", rob_empty); end
    do_reset;
    for (int c = 0; c < 7; c++) begin
      disp(0, 5'd1, 1'b1, 32'h0, 32'h4);
      disp(1, 5'd1, 1'b1, 32'h4, 32'h8);
      tick;
    end
    idle;
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL c14_ready got %b exp 1", dispatch_ready); end
    disp(0, 5'd1, 1'b1, 32'h0, 32'h4);
    tick;
    idle;
    checks++; if (rob_count !== 5'd15) begin errors++; $display("FAIL c15_count got %0d exp 15", rob_count); end
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL c15_ready got %b exp 0", dispatch_ready); end
    disp(0, 5'd1, 1'b1, 32'h0, 32'h4);
    disp(1, 5'd1, 1'b1, 32'h4, 32'h8);
    tick;
    idle;
    checks++; if (rob_count !== 5'd15) begin errors++; $display("FAIL c15_drop_count got %0d exp 15", rob_count); end
  endtask
  task automatic test_ooo_writeback;
    do_reset;
    for (int t = 0; t < 4; t += 2) begin
      disp(0, 5'(t + 10), 1'b1, 32'h1000 + 32'(4 * t), 32'h1004 + 32'(4 * t));
      disp(1, 5'(t + 11), 1'b1, 32'h1004 + 32'(4 * t), 32'h1008 + 32'(4 * t));
      tick;
    end
    idle;
    cdb(2, 4'd3, 32'hA3);
    tick;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_t3 got %b exp 00", commit_valid); end
    idle;
    cdb(1, 4'd2, 32'hA2);
    tick;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_t2 got %b exp 00", commit_valid); end
    idle;
    cdb(0, 4'd1, 32'hA1);
    cdb(1, 4'd3, 32'hDEAD);
    tick;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_t1 got %b exp 00", commit_valid); end
    idle;
    cdb(2, 4'd0, 32'hA0);
    tick;
    idle;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL ooo_c01_valid got %b exp 11", commit_valid); end
    checks++; if (commit_tag !== {4'd1, 4'd0}) begin errors++; $display("FAIL ooo_c01_tag got %h exp 10", commit_tag); end
    checks++; if (commit_rd_v[0] !== 32'hA0 || commit_rd_v[1] !== 32'hA1) begin errors++; $display("FAIL ooo_c01_rdv got %h %h exp a0 a1", commit_rd_v[0], commit_rd_v[1]); end
    checks++; if (commit_rd_s !== {5'd11, 5'd10} || commit_regf_we !== 2'b11) begin errors++; $display("FAIL ooo_c01_rd got %h we %b exp rd 11,10 we 11", commit_rd_s, commit_regf_we); end
    checks++; if (rob_count !== 5'd4) begin errors++; $display("FAIL ooo_c01_count got %0d exp 4", rob_count); end
    tick;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL ooo_c23_valid got %b exp 11", commit_valid); end
    checks++; if (commit_tag !== {4'd3, 4'd2}) begin errors++; $display("FAIL ooo_c23_tag got %h exp 32", commit_tag); end
    checks++; if (commit_rd_v[0] !== 32'hA2 || commit_rd_v[1] !== 32'hA3) begin errors++; $display("FAIL ooo_c23_rdv got %h %h exp a2 a3", commit_rd_v[0], commit_rd_v[1]); end
    checks++; if (commit_pc[0] !== 32'h1008 || commit_pc[1] !== 32'h100C) begin errors++; $display("FAIL ooo_c23_pc got %h %h exp 1008 100c", commit_pc[0], commit_pc[1]); end
    tick;
    checks++; if (rob_empty !== 1'b1 || commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_drain got empty %b valid %b exp 1 00", rob_empty, commit_valid); end
  endtask
  task automatic test_mispredict;
    do_reset;
    disp(0, 5'd3, 1'b1, 32'hFC, 32'h100);
    disp(1, 5'd0, 1'b0, 32'h100, 32'h104);
    tick;
    idle;
    disp(0, 5'd4, 1'b1, 32'h104, 32'h108);
    tick;
    idle;
    cdb(0, 4'd0, 32'h55);
    br_valid = 1'b1; br_tag = 4'd1; br_target = 32'h200; br_taken = 1'b1; br_rd_v = 32'h104;
    tick;
    idle;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL mp_valid got %b exp 11", commit_valid); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mp_flush got %b exp 1", flush); end
    checks++; if (flush_pc !== 32'h200) begin errors++; $display("FAIL mp_flush_pc got %h exp 200", flush_pc); end
    checks++; if (commit_br_taken[1] !== 1'b1 || commit_rd_v[0] !== 32'h55) begin errors++; $display("FAIL mp_lanes got taken %b rdv %h exp 1 55", commit_br_taken[1], commit_rd_v[0]); end
    checks++; if (rob_count !== 5'd3) begin errors++; $display("FAIL mp_count got %0d exp 3", rob_count); end
    disp(0, 5'd5, 1'b1, 32'h500, 32'h504);
    cdb(0, 4'd2, 32'h99);
    tick;
    idle;
    checks++; if (rob_count !== 5'd0 || rob_empty !== 1'b1) begin errors++; $display("FAIL mp_after_count got %0d empty %b exp 0 1", rob_count, rob_empty); end
    checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin errors++; $display("FAIL mp_after_flush got %b %h exp 0 0", flush, flush_pc); end
    checks++; if (commit_valid !== 2'b00 || dispatch_tag[0] !== 4'd0) begin errors++; $display("FAIL mp_after_ptr got valid %b tag %0d exp 00 0", commit_valid, dispatch_tag[0]); end
  endtask
  task automatic test_branch_correct;
    do_reset;
    disp(0, 5'd1, 1'b1, 32'h300, 32'h340);
    disp(1, 5'd0, 1'b0, 32'h340, 32'h344);
    tick;
    idle;
    br_valid = 1'b1; br_tag = 4'd0; br_target = 32'h340; br_taken = 1'b1; br_rd_v = 32'h304;
    cdb(0, 4'd1, 32'h77);
    tick;
    idle;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL br_valid got %b exp 11", commit_valid); end
    checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin errors++; $display("FAIL br_flush got %b %h exp 0 0", flush, flush_pc); end
    checks++; if (commit_br_taken !== 2'b01) begin errors++; $display("FAIL br_taken got %b exp 01", commit_br_taken); end
    checks++; if (commit_regf_we !== 2'b01 || commit_rd_v[0] !== 32'h304) begin errors++; $display("FAIL br_link got we %b rdv %h exp 01 304", commit_regf_we, commit_rd_v[0]); end
    checks++; if (commit_pc[1] !== 32'h340) begin errors++; $display("FAIL br_pc1 got %h exp 340", commit_pc[1]); end
    tick;
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL br_drain got %b exp 1", rob_empty); end
  endtask
  task automatic test_back_to_back;
    int seq;
    do_reset;
    for (int c = 0; c < 40; c++) begin
      idle;
      if (c < 36) begin
        checks++; if (dispatch_tag[0] !== 4'((2 * c) % 16)) begin errors++; $display("FAIL b2b_dtag c%0d got %0d exp %0d", c, dispatch_tag[0], (2 * c) % 16); end
        for (int k = 0; k < 2; k++) begin
          seq = 2 * c + k;
          disp(k, 5'(seq % 31 + 1), 1'b1, 32'h4000 + 32'(4 * seq), 32'h4004 + 32'(4 * seq));
        end
      end
      if (c >= 1 && c <= 36) begin
        for (int k = 0; k < 2; k++) begin
          seq = 2 * (c - 1) + k;
          cdb(k, 4'(seq % 16), 32'(seq) ^ 32'h5A5A0000);
        end
      end
      tick;
      if (c >= 1 && c <= 35) begin
        checks++; if (rob_count !== 5'd4) begin errors++; $display("FAIL b2b_count c%0d got %0d exp 4", c, rob_count); end
      end
      if (c >= 1 && c <= 36) begin
        checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL b2b_valid c%0d got %b exp 11", c, commit_valid); end
        for (int k = 0; k < 2; k++) begin
          seq = 2 * (c - 1) + k;
          checks++; if (commit_tag[k] !== 4'(seq % 16) || commit_pc[k] !== 32'h4000 + 32'(4 * seq) || commit_rd_v[k] !== (32'(seq) ^ 32'h5A5A0000)) begin
            errors++; $display("FAIL b2b_lane c%0d k%0d got tag %0d pc %h rdv %h exp tag %0d pc %h", c, k, commit_tag[k], commit_pc[k], commit_rd_v[k], seq % 16, 32'h4000 + 32'(4 * seq));
          end
        end
      end else begin
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL b2b_idle c%0d got %b exp 00", c, commit_valid); end
      end
    end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL b2b_drain got %b exp 1", rob_empty); end
  endtask
  task automatic test_reset_mid;
    do_reset;
    disp(0, 5'd1, 1'b1, 32'h10, 32'h14);
    disp(1, 5'd2, 1'b1, 32'h14, 32'h18);
    tick;
    tick;
    idle;
    disp(0, 5'd3, 1'b1, 32'h20, 32'h24);
    tick;
    idle;
    checks++; if (rob_count !== 5'd5) begin errors++; $display("FAIL rm_count5 got %0d exp 5", rob_count); end
    cdb(0, 4'd0, 32'h11);
    cdb(1, 4'd1, 32'h22);
    tick;
    idle;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL rm_precommit got %b exp 11", commit_valid); end
    rst = 1'b1;
    cdb(0, 4'd2, 32'h33);
    disp(0, 5'd4, 1'b1, 32'h30, 32'h34);
    #1;
    checks++; if (commit_valid !== 2'b00 || flush !== 1'b0) begin errors++; $display("FAIL rm_in_reset got valid %b flush %b exp 00 0", commit_valid, flush); end
    tick;
    rst = 1'b0;
    idle;
    #1;
    checks++; if (rob_empty !== 1'b1 || rob_count !== 5'd0) begin errors++; $display("FAIL rm_empty got %b count %0d exp 1 0", rob_empty, rob_count); end
    checks++; if (commit_valid !== 2'b00 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL rm_state got valid %b ready %b exp 00 1", commit_valid, dispatch_ready); end
    tick;
    checks++; if (rob_empty !== 1'b1 || dispatch_tag[0] !== 4'd0) begin errors++; $display("FAIL rm_hold got empty %b tag %0d exp 1 0", rob_empty, dispatch_tag[0]); end
  endtask
  initial begin
    idle;
    test_reset;
    test_fill;
    test_ooo_writeback;
    test_mispredict;
    test_branch_correct;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised successor to the single-issue reorder buffer, with N-wide in-order dispatch and M-wide in-order commit.
- Sits between decode/rename, the CDB and the branch unit, and the architectural regfile.
- Entries allocate at the tail, complete out of order, and retire in order from the head.
- A mispredicted branch retiring at the head drives a full flush plus a redirect PC.

Parameters:
ROB_DEPTH, 16, entry count; power of 2, >= 2*max(DISPATCH_WIDTH, COMMIT_WIDTH)
DISPATCH_WIDTH, 2, entries allocatable per cycle
COMMIT_WIDTH, 2, entries retirable per cycle
CDB_SIZE, 3, non-branch writeback channels
TW (localparam), $clog2(ROB_DEPTH), tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dispatch_valid[DISPATCH_WIDTH]  in  1  per-lane request; lanes contiguous from lane 0
dispatch_rd_s[DISPATCH_WIDTH]  in  5  destination register
dispatch_regf_we[DISPATCH_WIDTH]  in  1  writes rd
dispatch_pc[DISPATCH_WIDTH]  in  32  instruction PC
dispatch_pc_next[DISPATCH_WIDTH]  in  32  predicted next PC
dispatch_ready  out  1  free entries >= DISPATCH_WIDTH
dispatch_tag[DISPATCH_WIDTH]  out  TW  tag assigned to lane k = tail+k
cdb_valid[CDB_SIZE]  in  1  writeback valid
cdb_tag[CDB_SIZE]  in  TW  writeback tag
cdb_data[CDB_SIZE]  in  32  rd value
br_valid  in  1  branch resolved
br_tag  in  TW  branch tag
br_target  in  32  resolved next PC
br_taken  in  1  resolved direction
br_rd_v  in  32  link value (jal/jalr)
commit_valid[COMMIT_WIDTH]  out  1  lane retires this cycle
commit_tag[COMMIT_WIDTH]  out  TW  head+k
commit_regf_we[COMMIT_WIDTH]  out  1  regfile write enable (gated by commit_valid)
commit_rd_s[COMMIT_WIDTH]  out  5  rd
commit_rd_v[COMMIT_WIDTH]  out  32  rd value
commit_pc[COMMIT_WIDTH]  out  32  retiring PC
commit_br_taken[COMMIT_WIDTH]  out  1  branch taken, for predictor update
flush  out  1  mispredict retire
flush_pc  out  32  redirect target
rob_count  out  TW+1  occupied entries
rob_empty  out  1  rob_count==0

Behaviour:
- **Pointers.** head and tail are TW+1 bits; the extra bit is the wrap bit. count = tail-head, modulo 2^(TW+1). Full means count==ROB_DEPTH.
- **Entry state.** Each entry holds valid, ready, mispred, taken, regf_we, rd_s, rd_v, pc and pc_next.
- **Reset.** All entry valid/ready/mispred cleared; head=tail=0. Outputs: dispatch_ready=1, rob_count=0, rob_empty=1, commit_valid all 0, flush=0.
- **Dispatch.** Occurs when dispatch_ready && dispatch_valid[k].
  - Entry tail+k is written with valid=1, ready=0 at the next edge.
  - tail advances by popcount(dispatch_valid).
  - dispatch_ready is derived from registered count only. Slots freed by same-cycle commit are not reusable until the next cycle.
  - A non-contiguous valid pattern is illegal; the bench asserts on it.
- **CDB writeback.** If cdb_valid[j] and the entry is valid and not ready: set rd_v=cdb_data[j] and ready=1 at the next edge.
  - Two channels hitting the same tag: lowest j wins; this is flagged as a protocol error in simulation.
  - Writeback to an invalid or already-ready entry is ignored.
- **Branch resolve.** On br_valid for a valid entry:
  - set ready=1, taken=br_taken, rd_v=br_rd_v;
  - if br_target != stored pc_next, set mispred=1 and pc_next=br_target.
  - br and cdb never target the same tag in one cycle.
- **Ready visibility.** Ready is visible to commit one cycle after writeback. There is no CDB-to-commit bypass.
- **Commit (combinational from registered state).**
  - Lane k is valid iff entries head..head+k are all valid and ready, and no lower lane is a mispredicted entry.
  - A mispredicted entry itself commits; all younger lanes are suppressed.
  - head advances by the number of committed lanes. Committed entries are cleared to valid=0.
- **Flush.**
  - flush=1 in the cycle a committing lane has mispred=1. flush_pc = that entry's pc_next; otherwise flush_pc=0.
  - Next edge: all entries invalid, head=tail=0.
  - Dispatch, CDB and branch writes presented in the flush cycle are dropped. Only the mispredicting branch and older same-cycle lanes retire.
- **Reset priority.** rst has priority over flush, commit and dispatch. Reset mid-operation discards all entries with no commits.
- **Simultaneous dispatch + commit.** Count updates by dispatched minus committed.
- **Wrap-around.** Indices use the low TW bits only; this holds across wrap.
- **Latency.** Dispatch-to-earliest-commit is 2 cycles: write, then ready via CDB next cycle, then commit.

Test Plan:
1. Reset, then dispatch 2 lanes/cycle for 8 cycles with no writeback -> rob_count=16; dispatch_ready=0 from the cycle count reaches 15; no commits.
2. Dispatch tags 0-3, CDB completes 3,2,1,0 on consecutive cycles -> nothing commits until tag0 ready; then lanes retire tags 0,1 then 2,3 with in-order commit_rd_v values.
3. Branch at tag 1 (predicted 0x104) resolves br_target=0x200; tag 0 and tag 1 ready together -> same cycle commit_valid={1,1}, flush=1, flush_pc=0x200; next cycle rob_count=0, tag 2 discarded.
4. Branch resolves with br_target equal to prediction -> no flush; commit_br_taken reflects br_taken.
5. Run 40 dispatch/commit cycles at full width -> tags wrap 15->0 correctly; rob_count never exceeds 16; commit_pc sequence matches dispatch order.
6. Assert rst mid-stream with 5 entries outstanding and cdb_valid active -> next cycle rob_empty=1, no commit_valid, dispatch_ready=1.
